// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types and constants for the memory bus arbiter:
//               FSM state encoding, operation encoding, timeout defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Latched operation of the transaction currently owning the bus
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    // Default cycles to wait for a memory done before giving up
    localparam int C_TIMEOUT_CYC_DEF = 255;

    // Width of the XFER watchdog counter
    localparam int C_CNT_W = 8;

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_rr_picker
// Description : Combinational round-robin priority encoder. Scans requesters
//               starting one past the last owner and wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter_rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_any
);

    logic [IDW-1:0] w_idx;

    // Scan from the lowest priority upward so the final hit is the winner
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        w_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IDW'((int'(last) + k) % N);
            if (req[w_idx]) begin
                gnt_id  = w_idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule : mem_bus_arbiter_rr_picker
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Round-robin arbiter sharing one external memory bus between
//               N core-side masters. One transaction in flight; address,
//               data and op are latched at grant. halt_q parks the arbiter
//               in IDLE for dispatcher maintenance.
//               Optional macro BUS_ARB_TIMEOUT_EN adds an XFER watchdog and
//               the timeout_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N           = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int IDW         = $clog2(N),
    parameter int TIMEOUT_CYC = C_TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_read_q,
    input  logic [N-1:0]        req_write_q,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_data,
    output logic [N-1:0]        req_busy,
    output logic [N-1:0]        req_read_dn,
    output logic [N-1:0]        req_write_dn,
    output logic [DATA_W-1:0]   rd_data,
    output logic                mem_read_q,
    output logic                mem_write_q,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data_out,
    input  logic [DATA_W-1:0]   mem_data_in,
    input  logic                mem_read_dn,
    input  logic                mem_write_dn,
    input  logic                halt_q,
    output logic                halt_ack,
    output logic                grant_vld,
    output logic [IDW-1:0]      grant_id
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    localparam logic [N-1:0] C_ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    // Elaboration-time parameter sanity
    if (N < 2 || N > 8) begin : g_chk_n
        $error("mem_bus_arbiter: N must be in 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_chk_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYC must fit the 8-bit watchdog");
    end

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    arb_op_t        r_op;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_pick_id;
    logic           w_pick_any;
    logic           w_grant;
    logic           w_mem_dn;
    logic           w_owner_req;
    logic           w_timeout;
    logic [N-1:0]   w_owner_oh;
    logic [N-1:0]   w_pick_oh;

    mem_bus_arbiter_rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_picker (
        .req     (req_read_q | req_write_q),
        .last    (r_last),
        .gnt_id  (w_pick_id),
        .gnt_any (w_pick_any)
    );

    assign w_owner_oh  = C_ONE_HOT0 << grant_id;
    assign w_pick_oh   = C_ONE_HOT0 << w_pick_id;
    assign w_grant     = (r_state == ARB_IDLE) && !halt_q && w_pick_any;
    // Only the done strobe matching the latched op ends the transfer
    assign w_mem_dn    = (r_op == OP_WR) ? mem_write_dn : mem_read_dn;
    assign w_owner_req = req_read_q[grant_id] | req_write_q[grant_id];
    assign halt_ack    = (r_state == ARB_IDLE) && halt_q;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [C_CNT_W-1:0] r_cnt;
    assign w_timeout = (r_state == ARB_XFER) && (r_cnt == C_CNT_W'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant)                 w_state_nxt = ARB_XFER;
            ARB_XFER: if (w_mem_dn || w_timeout)   w_state_nxt = ARB_DONE;
            ARB_DONE: if (!w_owner_req)            w_state_nxt = ARB_IDLE;
            default:                               w_state_nxt = ARB_IDLE;
        endcase
    end

    // Grant bookkeeping, latched request, memory strobes and done pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op         <= OP_RD;
            r_last       <= IDW'(N - 1);
            grant_vld    <= 1'b0;
            grant_id     <= '0;
            req_busy     <= '0;
            req_read_dn  <= '0;
            req_write_dn <= '0;
            rd_data      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            req_read_dn  <= '0;
            req_write_dn <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        // Write wins when a requester asks for both
                        r_op         <= req_write_q[w_pick_id] ? OP_WR : OP_RD;
                        grant_vld    <= 1'b1;
                        grant_id     <= w_pick_id;
                        req_busy     <= ~w_pick_oh;
                        mem_write_q  <= req_write_q[w_pick_id];
                        mem_read_q   <= ~req_write_q[w_pick_id];
                        mem_addr     <= req_addr[int'(w_pick_id) * ADDR_W +: ADDR_W];
                        mem_data_out <= req_data[int'(w_pick_id) * DATA_W +: DATA_W];
`ifdef BUS_ARB_TIMEOUT_EN
                        r_cnt        <= '0;
`endif
                    end
                end
                ARB_XFER: begin
                    if (w_mem_dn) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (r_op == OP_WR) begin
                            req_write_dn <= w_owner_oh;
                        end else begin
                            req_read_dn <= w_owner_oh;
                            rd_data     <= mem_data_in;
                        end
`ifdef BUS_ARB_TIMEOUT_EN
                    end else if (w_timeout) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rd_data     <= '1;
                        timeout_err <= 1'b1;
                        if (r_op == OP_WR) begin
                            req_write_dn <= w_owner_oh;
                        end else begin
                            req_read_dn <= w_owner_oh;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                ARB_DONE: begin
                    if (!w_owner_req) begin
                        r_last    <= grant_id;
                        grant_vld <= 1'b0;
                        req_busy  <= '0;
                    end
                end
                default: begin
                    grant_vld <= 1'b0;
                    req_busy  <= '0;
                end
            endcase
        end
    end

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Scenario tasks plus a
//               randomized run against a round-robin reference model.
//               Define BUS_ARB_TIMEOUT_EN to also exercise the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_read_q = '0;
    logic [N-1:0]      req_write_q = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_busy;
    logic [N-1:0]      req_read_dn;
    logic [N-1:0]      req_write_dn;
    logic [DW-1:0]     rd_data;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_out;
    logic [DW-1:0]     mem_data_in = '0;
    logic              mem_read_dn = 1'b0;
    logic              mem_write_dn = 1'b0;
    logic              halt_q = 1'b0;
    logic              halt_ack;
    logic              grant_vld;
    logic [IDW-1:0]    grant_id;
`ifdef BUS_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    int total = 0;
    int bad   = 0;
    int m_last;  // model: last owner, drives round-robin priority

    mem_bus_arbiter #(
        .N (N), .ADDR_W (AW), .DATA_W (DW), .IDW (IDW), .TIMEOUT_CYC (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_read_q   (req_read_q),
        .req_write_q  (req_write_q),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_busy     (req_busy),
        .req_read_dn  (req_read_dn),
        .req_write_dn (req_write_dn),
        .rd_data      (rd_data),
        .mem_read_q   (mem_read_q),
        .mem_write_q  (mem_write_q),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_read_dn  (mem_read_dn),
        .mem_write_dn (mem_write_dn),
        .halt_q       (halt_q),
        .halt_ack     (halt_ack),
        .grant_vld    (grant_vld),
        .grant_id     (grant_id)
`ifdef BUS_ARB_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference rule: first requester scanning last+1, last+2, ... mod N
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read_q[i]          = rd;
        req_write_q[i]         = wr;
        req_addr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]   = d;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (grant_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        total++;
        if ({req_busy, req_read_dn, req_write_dn, grant_vld, grant_id, halt_ack} !== '0)
            begin bad++; $display("FAIL reset_ctl: busy=%b rdn=%b wdn=%b vld=%b id=%0d ack=%b, want all 0",
                req_busy, req_read_dn, req_write_dn, grant_vld, grant_id, halt_ack); end
        total++;
        if ({mem_read_q, mem_write_q, mem_addr, mem_data_out, rd_data} !== '0)
            begin bad++; $display("FAIL reset_mem: rq=%b wq=%b addr=%h dout=%h rd=%h, want all 0",
                mem_read_q, mem_write_q, mem_addr, mem_data_out, rd_data); end
        rst = 1'b1;
        m_last = N - 1;
        step();
    endtask

    task automatic test_fairness();
        bit ok;
        int exp;
        int prev;
        prev = -1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 32'h1000 + 32'(i * 16), 32'hA0 + 32'(i));
        for (int g = 0; g < 5; g++) begin
            exp = rr_pick(req_read_q | req_write_q, m_last);
            wait_grant(ok);
            total++;
            if (!ok || grant_id !== IDW'(exp))
                begin bad++; $display("FAIL fair_grant%0d: got id=%0d vld=%b, want id=%0d", g, grant_id, grant_vld, exp); end
            total++;
            if (int'(grant_id) == prev)
                begin bad++; $display("FAIL fair_repeat%0d: got id=%0d twice, want a different owner", g, grant_id); end
            total++;
            if (mem_write_q !== 1'b1 || mem_addr !== 32'h1000 + 32'(exp * 16) || mem_data_out !== 32'hA0 + 32'(exp))
                begin bad++; $display("FAIL fair_mem%0d: got wq=%b addr=%h dout=%h, want wq=1 addr=%h dout=%h",
                    g, mem_write_q, mem_addr, mem_data_out, 32'h1000 + 32'(exp * 16), 32'hA0 + 32'(exp)); end
            mem_write_dn = 1'b1;
            step();
            mem_write_dn = 1'b0;
            total++;
            if (req_write_dn !== onehot(exp))
                begin bad++; $display("FAIL fair_dn%0d: got %b, want %b", g, req_write_dn, onehot(exp)); end
            step();
            total++;
            if (grant_vld !== 1'b1)
                begin bad++; $display("FAIL fair_done_hold%0d: got vld=%b, want 1 while q held", g, grant_vld); end
            req_write_q[exp] = 1'b0;
            step();
            m_last = exp;
            prev = exp;
            if (g < 4) req_write_q[exp] = 1'b1;
        end
        req_write_q = '0;
        step();
    endtask

    task automatic test_single_read();
        set_req(2, 1'b1, 1'b0, 32'h100, 32'h0);
        step();
        total++;
        if (grant_vld !== 1'b1 || mem_read_q !== 1'b1 || mem_write_q !== 1'b0 || grant_id !== 2'd2)
            begin bad++; $display("FAIL sr_latency: got vld=%b rq=%b wq=%b id=%0d, want 1 1 0 2",
                grant_vld, mem_read_q, mem_write_q, grant_id); end
        total++;
        if (mem_addr !== 32'h100)
            begin bad++; $display("FAIL sr_addr: got %h, want 00000100", mem_addr); end
        total++;
        if (req_busy !== 4'b1011)
            begin bad++; $display("FAIL sr_busy: got %b, want 1011", req_busy); end
        step();
        step();
        mem_data_in = 32'hDEADBEEF;
        mem_read_dn = 1'b1;
        step();
        mem_read_dn = 1'b0;
        total++;
        if (req_read_dn !== 4'b0100 || mem_read_q !== 1'b0)
            begin bad++; $display("FAIL sr_dn: got rdn=%b rq=%b, want 0100 0", req_read_dn, mem_read_q); end
        total++;
        if (rd_data !== 32'hDEADBEEF)
            begin bad++; $display("FAIL sr_data: got %h, want deadbeef", rd_data); end
        step();
        total++;
        if (req_read_dn !== 4'b0000 || grant_vld !== 1'b1)
            begin bad++; $display("FAIL sr_pulse: got rdn=%b vld=%b, want 0000 1", req_read_dn, grant_vld); end
        req_read_q[2] = 1'b0;
        step();
        total++;
        if (grant_vld !== 1'b0 || req_busy !== 4'b0000)
            begin bad++; $display("FAIL sr_release: got vld=%b busy=%b, want 0 0000", grant_vld, req_busy); end
        m_last = 2;
    endtask

    task automatic test_halt();
        bit ok;
        set_req(1, 1'b0, 1'b1, 32'h200, 32'h55);
        wait_grant(ok);
        total++;
        if (!ok || grant_id !== 2'd1)
            begin bad++; $display("FAIL halt_first: got id=%0d vld=%b, want 1", grant_id, grant_vld); end
        halt_q = 1'b1;
        set_req(2, 1'b0, 1'b1, 32'h300, 32'h66);
        step();
        total++;
        if (halt_ack !== 1'b0 || mem_write_q !== 1'b1)
            begin bad++; $display("FAIL halt_xfer: got ack=%b wq=%b, want 0 1", halt_ack, mem_write_q); end
        mem_write_dn = 1'b1;
        step();
        mem_write_dn = 1'b0;
        total++;
        if (req_write_dn !== 4'b0010)
            begin bad++; $display("FAIL halt_dn: got %b, want 0010", req_write_dn); end
        req_write_q[1] = 1'b0;
        step();
        repeat (3) step();
        total++;
        if (grant_vld !== 1'b0 || halt_ack !== 1'b1)
            begin bad++; $display("FAIL halt_park: got vld=%b ack=%b, want 0 1", grant_vld, halt_ack); end
        halt_q = 1'b0;
        step();
        total++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd2 || halt_ack !== 1'b0)
            begin bad++; $display("FAIL halt_resume: got vld=%b id=%0d ack=%b, want 1 2 0", grant_vld, grant_id, halt_ack); end
        mem_write_dn = 1'b1;
        step();
        mem_write_dn = 1'b0;
        req_write_q[2] = 1'b0;
        step();
        m_last = 2;
    endtask

    task automatic test_abort_addr();
        bit ok;
        set_req(1, 1'b1, 1'b0, 32'h400, 32'h0);
        wait_grant(ok);
        total++;
        if (!ok || grant_id !== 2'd1)
            begin bad++; $display("FAIL ab_grant: got id=%0d vld=%b, want 1", grant_id, grant_vld); end
        req_addr[1*AW +: AW] = 32'h0000BAD0;
        mem_write_dn = 1'b1;
        step();
        mem_write_dn = 1'b0;
        total++;
        if (mem_addr !== 32'h400 || mem_read_q !== 1'b1 || req_read_dn !== '0 || req_write_dn !== '0)
            begin bad++; $display("FAIL ab_latch: got addr=%h rq=%b rdn=%b wdn=%b, want 00000400 1 0000 0000",
                mem_addr, mem_read_q, req_read_dn, req_write_dn); end
        req_read_q[1] = 1'b0;
        step();
        total++;
        if (mem_read_q !== 1'b1 || grant_vld !== 1'b1)
            begin bad++; $display("FAIL ab_inflight: got rq=%b vld=%b, want 1 1", mem_read_q, grant_vld); end
        mem_data_in = 32'h12345678;
        mem_read_dn = 1'b1;
        step();
        mem_read_dn = 1'b0;
        total++;
        if (req_read_dn !== 4'b0010 || rd_data !== 32'h12345678)
            begin bad++; $display("FAIL ab_dn: got rdn=%b rd=%h, want 0010 12345678", req_read_dn, rd_data); end
        step();
        total++;
        if (grant_vld !== 1'b0)
            begin bad++; $display("FAIL ab_exit: got vld=%b, want 0", grant_vld); end
        m_last = 1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_req(2, 1'b0, 1'b1, 32'h500, 32'h77);
        wait_grant(ok);
        total++;
        if (!ok || mem_write_q !== 1'b1)
            begin bad++; $display("FAIL rm_grant: got vld=%b wq=%b, want 1 1", grant_vld, mem_write_q); end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (mem_write_q !== 1'b0 || grant_vld !== 1'b0 || req_busy !== '0)
            begin bad++; $display("FAIL rm_async: got wq=%b vld=%b busy=%b, want 0 0 0000", mem_write_q, grant_vld, req_busy); end
        req_write_q = '0;
        step();
        rst = 1'b1;
        m_last = N - 1;
        set_req(0, 1'b0, 1'b1, 32'h600, 32'h88);
        set_req(3, 1'b0, 1'b1, 32'h700, 32'h99);
        step();
        total++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd0 || mem_addr !== 32'h600)
            begin bad++; $display("FAIL rm_prio: got vld=%b id=%0d addr=%h, want 1 0 00000600", grant_vld, grant_id, mem_addr); end
        mem_write_dn = 1'b1;
        step();
        mem_write_dn = 1'b0;
        req_write_q = '0;
        step();
        m_last = 0;
    endtask

    task automatic test_random();
        logic [N-1:0]  rq, wq, eb, erd, ewr;
        logic [AW-1:0] a [N];
        logic [DW-1:0] d [N];
        logic [DW-1:0] rdv;
        int            exp, lat, kk;
        bit            ok, exp_wr;
        rq = '0;
        wq = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = $urandom;
            d[i] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rq[i] = 1'($urandom);
                wq[i] = 1'($urandom);
            end
            set_req(i, rq[i], wq[i], a[i], d[i]);
        end
        for (int it = 0; it < 24; it++) begin
            if ((rq | wq) == '0) begin
                kk = $urandom_range(0, N - 1);
                rq[kk] = 1'b1;
                set_req(kk, 1'b1, wq[kk], a[kk], d[kk]);
            end
            exp    = rr_pick(rq | wq, m_last);
            exp_wr = wq[exp];
            eb     = ~onehot(exp);
            wait_grant(ok);
            total++;
            if (!ok || grant_id !== IDW'(exp) || req_busy !== eb)
                begin bad++; $display("FAIL rnd_grant%0d: got vld=%b id=%0d busy=%b, want id=%0d busy=%b",
                    it, grant_vld, grant_id, req_busy, exp, eb); end
            total++;
            if (mem_addr !== a[exp] || (exp_wr && mem_data_out !== d[exp]))
                begin bad++; $display("FAIL rnd_latch%0d: got addr=%h dout=%h, want addr=%h dout=%h",
                    it, mem_addr, mem_data_out, a[exp], d[exp]); end
            req_addr[exp*AW +: AW] = ~a[exp];
            lat = $urandom_range(0, 3);
            for (int c = 0; c < lat; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (exp_wr) mem_read_dn = 1'b1;
                    else        mem_write_dn = 1'b1;
                end
                step();
                mem_read_dn  = 1'b0;
                mem_write_dn = 1'b0;
            end
            total++;
            if (mem_addr !== a[exp] || mem_write_q !== exp_wr || mem_read_q !== !exp_wr)
                begin bad++; $display("FAIL rnd_hold%0d: got addr=%h wq=%b rq=%b, want addr=%h wq=%b rq=%b",
                    it, mem_addr, mem_write_q, mem_read_q, a[exp], exp_wr, !exp_wr); end
            req_addr[exp*AW +: AW] = a[exp];
            rdv = $urandom;
            mem_data_in = rdv;
            if (exp_wr) mem_write_dn = 1'b1;
            else        mem_read_dn  = 1'b1;
            step();
            mem_read_dn  = 1'b0;
            mem_write_dn = 1'b0;
            erd = exp_wr ? '0 : onehot(exp);
            ewr = exp_wr ? onehot(exp) : '0;
            total++;
            if (req_read_dn !== erd || req_write_dn !== ewr)
                begin bad++; $display("FAIL rnd_dn%0d: got rdn=%b wdn=%b, want %b %b", it, req_read_dn, req_write_dn, erd, ewr); end
            if (!exp_wr) begin
                total++;
                if (rd_data !== rdv)
                    begin bad++; $display("FAIL rnd_rdata%0d: got %h, want %h", it, rd_data, rdv); end
            end
            rq[exp] = 1'b0;
            wq[exp] = 1'b0;
            set_req(exp, 1'b0, 1'b0, a[exp], d[exp]);
            step();
            total++;
            if (grant_vld !== 1'b0 || req_busy !== '0 || req_read_dn !== '0 || req_write_dn !== '0)
                begin bad++; $display("FAIL rnd_release%0d: got vld=%b busy=%b rdn=%b wdn=%b, want all 0",
                    it, grant_vld, req_busy, req_read_dn, req_write_dn); end
            m_last = exp;
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && !wq[i] && $urandom_range(0, 2) != 0) begin
                    rq[i] = 1'($urandom);
                    wq[i] = 1'($urandom);
                    a[i]  = $urandom;
                    d[i]  = $urandom;
                    set_req(i, rq[i], wq[i], a[i], d[i]);
                end
            end
        end
        req_read_q  = '0;
        req_write_q = '0;
        step();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit seen;
        int cyc;
        seen = 1'b0;
        cyc  = 0;
        set_req(0, 1'b1, 1'b0, 32'h800, 32'h0);
        wait_grant(ok);
        for (int c = 0; c < 300; c++) begin
            step();
            cyc++;
            if (req_read_dn[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || timeout_err !== 1'b1 || cyc < 255 || cyc > 257)
            begin bad++; $display("FAIL to_pulse: got seen=%b err=%b after %0d cycles, want 1 1 near 256",
                seen, timeout_err, cyc); end
        total++;
        if (rd_data !== 32'hFFFFFFFF || mem_read_q !== 1'b0)
            begin bad++; $display("FAIL to_data: got rd=%h rq=%b, want ffffffff 0", rd_data, mem_read_q); end
        req_read_q[0] = 1'b0;
        step();
        total++;
        if (timeout_err !== 1'b0 || grant_vld !== 1'b0)
            begin bad++; $display("FAIL to_clear: got err=%b vld=%b, want 0 0", timeout_err, grant_vld); end
        m_last = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_halt();
        test_abort_addr();
        test_reset_mid();
        test_random();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, want completion");
        $fatal(1);
    end

endmodule : tb_mem_bus_arbiter
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between N core-side bus masters (per-core InternalBus read_q/write_q/addr/data groups).
- Round-robin grant; one transaction in flight at a time.
- Drives each requester's bus_busy and forwards read_dn/write_dn back.
- Sits between the core array and the memory/dispatcher port; halt_q freezes new grants for dispatcher maintenance.

Parameters:
N, 4, number of requesters (2..8)
ADDR_W, 32, address width (matches ADDR_SIZE0+1)
DATA_W, 32, data width (matches DATA_SIZE0+1)
IDW, 2, grant index width, clog2(N)
TIMEOUT_CYC, 255, max cycles awaiting mem done (only with BUS_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req_read_q  in  N  per-requester read request
req_write_q  in  N  per-requester write request
req_addr  in  N*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N*DATA_W  flattened write data
req_busy  out  N  bus_busy to requester i: bus owned by another requester
req_read_dn  out  N  one-cycle read-done pulse to requester i
req_write_dn  out  N  one-cycle write-done pulse to requester i
rd_data  out  DATA_W  captured read data, broadcast, valid with req_read_dn
mem_read_q  out  1  read strobe to memory
mem_write_q  out  1  write strobe to memory
mem_addr  out  ADDR_W  latched address
mem_data_out  out  DATA_W  latched write data
mem_data_in  in  DATA_W  memory read data
mem_read_dn  in  1  memory read complete
mem_write_dn  in  1  memory write complete
halt_q  in  1  block new grants
halt_ack  out  1  high in IDLE while halt_q is high
grant_vld  out  1  a transaction owns the bus
grant_id  out  IDW  current owner index

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state IDLE.
  - Round-robin pointer last = N-1, so requester 0 has first priority.
- Requester handshake: hold q, addr and data stable until done pulse; drop q the cycle after dn.
- IDLE:
  - If halt_q=1: no grant; halt_ack=1.
  - Else, if any (req_read_q|req_write_q), pick the first requester scanning last+1, last+2, ... mod N.
  - Latch its addr, data and op; set grant_id, grant_vld=1; go XFER.
  - Latency: request seen at edge t; mem_*_q high after edge t+1.
- XFER:
  - mem_read_q or mem_write_q held high; mem_addr and mem_data_out come from the latch, not live inputs.
  - On mem_read_dn or mem_write_dn (matching op):
    - capture mem_data_in into rd_data (reads only);
    - pulse req_*_dn[grant_id] for exactly 1 cycle;
    - drop mem_*_q the same edge; go DONE.
  - A mismatched dn (e.g. write_dn during a read) is ignored.
- DONE:
  - Wait until the owner's req_read_q and req_write_q are both 0.
  - Then set last=grant_id, grant_vld=0, go IDLE.
  - No back-to-back grant to the same requester without passing IDLE.
- req_busy[i] = grant_vld & (grant_id != i), registered, same timing as grant_vld.
- Read and write both high from the winner: write served first; read stays pending and is served on a later grant.
- Requester drops q during XFER (abort): the memory transaction still completes, the dn pulse is still issued, and DONE exits immediately.
- halt_q rising during XFER/DONE: the current transaction completes; the block then parks in IDLE with halt_ack=1.
- Reset mid-XFER: mem strobes drop immediately; the in-flight transaction is lost.

Optional Feature:
- BUS_ARB_TIMEOUT_EN defined:
  - 8-bit counter cleared on entering XFER, incremented each XFER cycle.
  - When it reaches TIMEOUT_CYC: drop mem_*_q, pulse the owner's dn, set rd_data to all ones, pulse extra output port timeout_err for 1 cycle, go DONE.
  - A late dn arriving in DONE/IDLE is ignored.
- Undefined: no counter, no timeout_err port; XFER waits indefinitely.

Decomposition:
- Shared include bus_arb_defs.v: state encodings ARB_IDLE=2'd0, ARB_XFER=2'd1, ARB_DONE=2'd2; default TIMEOUT_CYC; op encoding (OP_RD, OP_WR).
- Width macros stay in sizes.v.
- One sub-module, rr_picker: combinational round-robin priority encoder. Inputs req[N] and last[IDW]; outputs gnt_id and gnt_any.

Test Plan:
- Single read: req_read_q[2]=1, addr=0x100; mem_read_dn 3 cycles later with data 0xDEADBEEF -> mem_read_q high from t+1; req_read_dn[2] 1-cycle pulse; rd_data=0xDEADBEEF; req_busy=4'b1011 during XFER.
- Fairness: all 4 requesters hold writes continuously -> grant order 0,1,2,3,0; no requester granted twice in a row.
- Halt: halt_q asserted mid-XFER of requester 1 -> transaction completes; no new grant; halt_ack=1; deassert -> requester 2 granted next.
- Abort and address stability: change req_addr[1] during XFER -> mem_addr keeps the latched value. Requester drops q mid-XFER -> dn still pulsed; DONE exits in 1 cycle.
- Reset: rst=0 during XFER -> mem_write_q, grant_vld and req_busy go 0 asynchronously; after release, requester 0 wins a simultaneous 0/3 request.
- With BUS_ARB_TIMEOUT_EN: no mem dn for 255 cycles -> timeout_err pulse; req_read_dn pulse; rd_data=0xFFFFFFFF.
